// File: rtl/lsu_mem_port_arbiter.sv
// Arbitrates the single data-memory port between load issue and store-buffer drain.
// Optional build macro LSU_ARB_PERF_EN adds grant/stall performance counters.
module lsu_mem_port_arbiter #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int ROB_WIDTH     = 6,
  parameter int PHY_WIDTH     = 7,
  parameter int SB_HIGH_WATER = 6,
  parameter int STARVE_LIMIT  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  ld_req_valid,
  output logic                  ld_req_ready,
  input  logic [ADDR_WIDTH-1:0] ld_req_addr,
  input  logic [2:0]            ld_req_funct3,
  input  logic [ROB_WIDTH-1:0]  ld_req_rob_id,
  input  logic [PHY_WIDTH-1:0]  ld_req_rd_phy,
  input  logic                  st_req_valid,
  output logic                  st_req_ready,
  input  logic [ADDR_WIDTH-1:0] st_req_addr,
  input  logic [DATA_WIDTH-1:0] st_req_data,
  input  logic [2:0]            st_req_funct3,
  input  logic [3:0]            sb_occupancy,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_we,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [DATA_WIDTH-1:0] mem_req_wdata,
  output logic [3:0]            mem_req_wstrb,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_resp_rdata,
  output logic                  ld_resp_valid,
  output logic [DATA_WIDTH-1:0] ld_resp_data,
  output logic [ROB_WIDTH-1:0]  ld_resp_rob_id,
  output logic [PHY_WIDTH-1:0]  ld_resp_rd_phy
`ifdef LSU_ARB_PERF_EN
  ,
  output logic [31:0]           perf_ld_grants,
  output logic [31:0]           perf_st_grants,
  output logic [31:0]           perf_stall_cycles
`endif
);

  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_LIMIT[STARVE_W-1:0];
  localparam logic [3:0] SB_HW = SB_HIGH_WATER[3:0];

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                state;
  logic [STARVE_W-1:0]   starve_cnt;
  logic                  kill;
  logic [2:0]            ld_funct3_r;
  logic [1:0]            ld_off_r;
  logic [ROB_WIDTH-1:0]  ld_rob_r;
  logic [PHY_WIDTH-1:0]  ld_phy_r;

  logic                  st_wins;
  logic                  grant_st;
  logic                  grant_ld;
  logic [1:0]            st_off;
  logic [3:0]            st_strb;
  logic [DATA_WIDTH-1:0] st_wdata;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [DATA_WIDTH-1:0] ld_fmt;

  // Stores win when loads are absent, the buffer is near full, or loads have hogged the port.
  always_comb begin
    st_wins  = st_req_valid &&
               (!ld_req_valid || (sb_occupancy >= SB_HW) || (starve_cnt >= STARVE_MAX));
    grant_st = !rst && (state == IDLE) && st_wins;
    grant_ld = !rst && (state == IDLE) && !st_wins && ld_req_valid && !flush;
  end

  assign st_req_ready = grant_st;
  assign ld_req_ready = grant_ld;

  always_comb begin
    st_off   = st_req_addr[1:0];
    st_strb  = 4'hF;
    st_wdata = st_req_data;
    case (st_req_funct3)
      F3_B: begin
        st_strb  = 4'b0001 << st_off;
        st_wdata = st_req_data << {st_off, 3'b000};
      end
      F3_H: begin
        st_strb  = 4'b0011 << {st_off[1], 1'b0};
        st_wdata = st_req_data << {st_off[1], 4'b0000};
      end
      default: begin
        st_strb  = 4'hF;
        st_wdata = st_req_data;
      end
    endcase
  end

  // Lane select and extension of the returned word for the latched load.
  always_comb begin
    ld_byte = mem_resp_rdata[{ld_off_r, 3'b000} +: 8];
    ld_half = mem_resp_rdata[{ld_off_r[1], 4'b0000} +: 16];
    case (ld_funct3_r)
      F3_B:    ld_fmt = {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
      F3_H:    ld_fmt = {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
      F3_BU:   ld_fmt = {{(DATA_WIDTH-8){1'b0}}, ld_byte};
      F3_HU:   ld_fmt = {{(DATA_WIDTH-16){1'b0}}, ld_half};
      default: ld_fmt = mem_resp_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      starve_cnt     <= '0;
      kill           <= 1'b0;
      ld_funct3_r    <= '0;
      ld_off_r       <= '0;
      ld_rob_r       <= '0;
      ld_phy_r       <= '0;
      mem_req_valid  <= 1'b0;
      mem_req_we     <= 1'b0;
      mem_req_addr   <= '0;
      mem_req_wdata  <= '0;
      mem_req_wstrb  <= '0;
      ld_resp_valid  <= 1'b0;
      ld_resp_data   <= '0;
      ld_resp_rob_id <= '0;
      ld_resp_rd_phy <= '0;
    end else begin
      ld_resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          kill <= 1'b0;
          if (grant_st) begin
            state         <= REQ;
            mem_req_valid <= 1'b1;
            mem_req_we    <= 1'b1;
            mem_req_addr  <= {st_req_addr[ADDR_WIDTH-1:2], 2'b00};
            mem_req_wdata <= st_wdata;
            mem_req_wstrb <= st_strb;
            starve_cnt    <= '0;
          end else if (grant_ld) begin
            state         <= REQ;
            mem_req_valid <= 1'b1;
            mem_req_we    <= 1'b0;
            mem_req_addr  <= {ld_req_addr[ADDR_WIDTH-1:2], 2'b00};
            mem_req_wdata <= '0;
            mem_req_wstrb <= '0;
            ld_funct3_r   <= ld_req_funct3;
            ld_off_r      <= ld_req_addr[1:0];
            ld_rob_r      <= ld_req_rob_id;
            ld_phy_r      <= ld_req_rd_phy;
            if (st_req_valid && (starve_cnt < STARVE_MAX))
              starve_cnt <= starve_cnt + 1'b1;
          end
        end
        REQ: begin
          // A flushed load still completes its handshake; only its result is dropped.
          if (!mem_req_we && flush)
            kill <= 1'b1;
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= mem_req_we ? IDLE : RESP;
          end
        end
        RESP: begin
          if (flush)
            kill <= 1'b1;
          if (mem_resp_valid) begin
            state <= IDLE;
            if (!kill && !flush) begin
              ld_resp_valid  <= 1'b1;
              ld_resp_data   <= ld_fmt;
              ld_resp_rob_id <= ld_rob_r;
              ld_resp_rd_phy <= ld_phy_r;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LSU_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_ld_grants    <= '0;
      perf_st_grants    <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (grant_ld)
        perf_ld_grants <= perf_ld_grants + 32'd1;
      if (grant_st)
        perf_st_grants <= perf_st_grants + 32'd1;
      if (mem_req_valid && !mem_req_ready)
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lsu_mem_port_arbiter.sv
// Self-checking bench for lsu_mem_port_arbiter: vector table, corner-case sequences,
// and randomized transactions checked against a lane/extension reference model.
module tb_lsu_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        ld_req_valid;
  logic        ld_req_ready;
  logic [31:0] ld_req_addr;
  logic [2:0]  ld_req_funct3;
  logic [5:0]  ld_req_rob_id;
  logic [6:0]  ld_req_rd_phy;
  logic        st_req_valid;
  logic        st_req_ready;
  logic [31:0] st_req_addr;
  logic [31:0] st_req_data;
  logic [2:0]  st_req_funct3;
  logic [3:0]  sb_occupancy;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_we;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;
  logic        ld_resp_valid;
  logic [31:0] ld_resp_data;
  logic [5:0]  ld_resp_rob_id;
  logic [6:0]  ld_resp_rd_phy;
`ifdef LSU_ARB_PERF_EN
  logic [31:0] perf_ld_grants;
  logic [31:0] perf_st_grants;
  logic [31:0] perf_stall_cycles;
`endif

  lsu_mem_port_arbiter dut (
    .clk(clk), .rst(rst), .flush(flush),
    .ld_req_valid(ld_req_valid), .ld_req_ready(ld_req_ready), .ld_req_addr(ld_req_addr),
    .ld_req_funct3(ld_req_funct3), .ld_req_rob_id(ld_req_rob_id), .ld_req_rd_phy(ld_req_rd_phy),
    .st_req_valid(st_req_valid), .st_req_ready(st_req_ready), .st_req_addr(st_req_addr),
    .st_req_data(st_req_data), .st_req_funct3(st_req_funct3), .sb_occupancy(sb_occupancy),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .ld_resp_valid(ld_resp_valid), .ld_resp_data(ld_resp_data),
    .ld_resp_rob_id(ld_resp_rob_id), .ld_resp_rd_phy(ld_resp_rd_phy)
`ifdef LSU_ARB_PERF_EN
    , .perf_ld_grants(perf_ld_grants), .perf_st_grants(perf_st_grants),
    .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit          is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] rdata;
    int          mem_dly;
    int          resp_dly;
    logic [31:0] exp_addr;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_wdata;
    logic [31:0] exp_resp;
  } vec_t;

  vec_t vecs[12];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: pick the lane by access size, then extend by plain arithmetic.
  function automatic int unsigned accSize(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic int unsigned accLane(input logic [2:0] f3, input logic [1:0] off);
    int unsigned sz = accSize(f3);
    return (sz == 4) ? 0 : (int'(off) / sz) * sz;
  endfunction

  function automatic logic [31:0] refLoad(input logic [2:0] f3, input logic [1:0] off,
                                          input logic [31:0] word);
    int unsigned sz   = accSize(f3);
    int unsigned lane = accLane(f3, off);
    logic [31:0] r;
    r = word >> (8 * lane);
    if (sz < 4) begin
      r = r & ((32'd1 << (8 * sz)) - 32'd1);
      if (!f3[2] && r[8*sz-1])
        r = r - (32'd1 << (8 * sz));
    end
    return r;
  endfunction

  function automatic vec_t refStore(input logic [2:0] f3, input logic [31:0] addr,
                                    input logic [31:0] data);
    vec_t v;
    int unsigned sz   = accSize(f3);
    int unsigned lane = accLane(f3, addr[1:0]);
    v           = '{default: '0};
    v.is_store  = 1'b1;
    v.funct3    = f3;
    v.addr      = addr;
    v.data      = data;
    v.exp_addr  = addr & 32'hFFFF_FFFC;
    v.exp_wstrb = 4'(((32'd1 << sz) - 32'd1) << lane);
    v.exp_wdata = data << (8 * lane);
    return v;
  endfunction

  // Runs one complete transaction through an idle DUT with no competing request.
  task automatic applyStimulus(input vec_t v, input logic [5:0] rob, input logic [6:0] phy);
    if (v.is_store) begin
      st_req_valid  = 1'b1;
      st_req_addr   = v.addr;
      st_req_data   = v.data;
      st_req_funct3 = v.funct3;
      sb_occupancy  = 4'd1;
    end else begin
      ld_req_valid  = 1'b1;
      ld_req_addr   = v.addr;
      ld_req_funct3 = v.funct3;
      ld_req_rob_id = rob;
      ld_req_rd_phy = phy;
    end
    #1;
    checkOutput("req_ready", v.is_store ? st_req_ready : ld_req_ready, 32'd1);
    tick();
    checkOutput("ready_after_accept", v.is_store ? st_req_ready : ld_req_ready, 32'd0);
    st_req_valid = 1'b0;
    ld_req_valid = 1'b0;
    for (int i = 0; i <= v.mem_dly; i++) begin
      checkOutput("mem_req_valid", mem_req_valid, 32'd1);
      checkOutput("mem_req_we", mem_req_we, v.is_store);
      checkOutput("mem_req_addr", mem_req_addr, v.exp_addr);
      if (v.is_store) begin
        checkOutput("mem_req_wstrb", mem_req_wstrb, v.exp_wstrb);
        checkOutput("mem_req_wdata", mem_req_wdata, v.exp_wdata);
      end
      mem_req_ready = (i == v.mem_dly);
      tick();
    end
    mem_req_ready = 1'b0;
    checkOutput("mem_req_valid_clear", mem_req_valid, 32'd0);
    if (!v.is_store) begin
      for (int i = 0; i < v.resp_dly; i++) begin
        checkOutput("early_resp", ld_resp_valid, 32'd0);
        tick();
      end
      mem_resp_valid = 1'b1;
      mem_resp_rdata = v.rdata;
      tick();
      mem_resp_valid = 1'b0;
      checkOutput("ld_resp_valid", ld_resp_valid, 32'd1);
      checkOutput("ld_resp_data", ld_resp_data, v.exp_resp);
      checkOutput("ld_resp_rob_id", ld_resp_rob_id, rob);
      checkOutput("ld_resp_rd_phy", ld_resp_rd_phy, phy);
      tick();
      checkOutput("ld_resp_pulse", ld_resp_valid, 32'd0);
    end
  endtask

  // Serves whichever request the DUT grants next; memory answers immediately.
  task automatic serveOne(output bit was_store);
    int waited = 0;
    #1;
    while (!ld_req_ready && !st_req_ready && waited < 20) begin
      tick();
      waited++;
    end
    checkOutput("grant_seen", ld_req_ready | st_req_ready, 32'd1);
    checkOutput("single_grant", ld_req_ready & st_req_ready, 32'd0);
    was_store = st_req_ready;
    tick();
    checkOutput("serve_we", mem_req_we, was_store);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    if (!was_store) begin
      mem_resp_valid = 1'b1;
      mem_resp_rdata = $urandom;
      tick();
      mem_resp_valid = 1'b0;
      checkOutput("serve_resp", ld_resp_valid, 32'd1);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    bit   ws;
    vec_t v;
    int   occ;
    logic [2:0] ld_f3s[5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    rst = 1'b1; flush = 1'b0;
    ld_req_valid = 1'b0; ld_req_addr = '0; ld_req_funct3 = '0; ld_req_rob_id = '0; ld_req_rd_phy = '0;
    st_req_valid = 1'b0; st_req_addr = '0; st_req_data = '0; st_req_funct3 = '0; sb_occupancy = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;

    // is_store f3 addr data rdata mem_dly resp_dly exp_addr exp_wstrb exp_wdata exp_resp
    vecs[0]  = '{1'b0, 3'b001, 32'h102, 32'h0, 32'h8001_0000, 0, 0, 32'h100, 4'h0, 32'h0, 32'hFFFF_8001};
    vecs[1]  = '{1'b0, 3'b000, 32'h103, 32'h0, 32'h80AA_BBCC, 1, 0, 32'h100, 4'h0, 32'h0, 32'hFFFF_FF80};
    vecs[2]  = '{1'b0, 3'b100, 32'h101, 32'h0, 32'h1234_F6AA, 0, 1, 32'h100, 4'h0, 32'h0, 32'h0000_00F6};
    vecs[3]  = '{1'b0, 3'b101, 32'h200, 32'h0, 32'hDEAD_BEEF, 5, 2, 32'h200, 4'h0, 32'h0, 32'h0000_BEEF};
    vecs[4]  = '{1'b0, 3'b010, 32'h007, 32'h0, 32'hCAFE_F00D, 0, 0, 32'h004, 4'h0, 32'h0, 32'hCAFE_F00D};
    vecs[5]  = '{1'b0, 3'b001, 32'h000, 32'h0, 32'h0000_7FFF, 0, 0, 32'h000, 4'h0, 32'h0, 32'h0000_7FFF};
    vecs[6]  = '{1'b0, 3'b000, 32'h002, 32'h0, 32'h0045_0000, 2, 0, 32'h000, 4'h0, 32'h0, 32'h0000_0045};
    vecs[7]  = '{1'b1, 3'b000, 32'h013, 32'hAB, 32'h0, 0, 0, 32'h010, 4'b1000, 32'hAB00_0000, 32'h0};
    vecs[8]  = '{1'b1, 3'b001, 32'h022, 32'h1234, 32'h0, 5, 0, 32'h020, 4'b1100, 32'h1234_0000, 32'h0};
    vecs[9]  = '{1'b1, 3'b010, 32'h040, 32'hDEAD_BEEF, 32'h0, 1, 0, 32'h040, 4'b1111, 32'hDEAD_BEEF, 32'h0};
    vecs[10] = '{1'b1, 3'b000, 32'h031, 32'h5A, 32'h0, 0, 0, 32'h030, 4'b0010, 32'h0000_5A00, 32'h0};
    vecs[11] = '{1'b1, 3'b001, 32'h000, 32'hBEEF, 32'h0, 0, 0, 32'h000, 4'b0011, 32'h0000_BEEF, 32'h0};

    repeat (3) tick();
    rst = 1'b0;
    #1;
    checkOutput("reset_mem_req_valid", mem_req_valid, 32'd0);
    checkOutput("reset_mem_req_addr", mem_req_addr, 32'd0);
    checkOutput("reset_mem_req_wstrb", mem_req_wstrb, 32'd0);
    checkOutput("reset_ld_resp_valid", ld_resp_valid, 32'd0);
    checkOutput("reset_ld_resp_data", ld_resp_data, 32'd0);
    checkOutput("reset_ld_req_ready", ld_req_ready, 32'd0);
    checkOutput("reset_st_req_ready", st_req_ready, 32'd0);
    tick();

    $display("[TB] vector table");
    for (int i = 0; i < 12; i++)
      applyStimulus(vecs[i], 6'(i + 3), 7'(i * 5 + 1));

    $display("[TB] starvation override");
    sb_occupancy  = 4'd2;
    st_req_valid  = 1'b1; st_req_addr = 32'h80; st_req_data = 32'h1111_2222; st_req_funct3 = 3'b010;
    ld_req_valid  = 1'b1; ld_req_addr = 32'h100; ld_req_funct3 = 3'b010;
    for (int g = 0; g < 9; g++) begin
      serveOne(ws);
      checkOutput($sformatf("starve_grant%0d_is_store", g), ws, (g == 8));
    end
    serveOne(ws);
    checkOutput("starve_cleared_load_first", ws, 32'd0);
    ld_req_valid = 1'b0;
    serveOne(ws);
    checkOutput("starve_store_alone", ws, 32'd1);
    st_req_valid = 1'b0;

    $display("[TB] high-water override");
    sb_occupancy = 4'd6;
    st_req_valid = 1'b1;
    ld_req_valid = 1'b1;
    serveOne(ws);
    checkOutput("highwater_store_first", ws, 32'd1);
    st_req_valid = 1'b0;
    serveOne(ws);
    checkOutput("highwater_load_next", ws, 32'd0);
    ld_req_valid = 1'b0;

    $display("[TB] flush in idle blocks load");
    ld_req_valid = 1'b1; flush = 1'b1;
    #1;
    checkOutput("flush_idle_ready", ld_req_ready, 32'd0);
    tick();
    checkOutput("flush_idle_no_req", mem_req_valid, 32'd0);
    ld_req_valid = 1'b0; flush = 1'b0;
    tick();

    $display("[TB] flush while load in response phase");
    ld_req_valid = 1'b1; ld_req_addr = 32'h10; ld_req_funct3 = 3'b010; ld_req_rob_id = 6'd5;
    #1;
    tick();
    ld_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'h1357_9BDF;
    tick();
    mem_resp_valid = 1'b0;
    checkOutput("flush_resp_suppressed", ld_resp_valid, 32'd0);
    tick();
    checkOutput("flush_resp_still_quiet", ld_resp_valid, 32'd0);
    applyStimulus(vecs[4], 6'd9, 7'd17);

    $display("[TB] flush while load request is stalled");
    ld_req_valid = 1'b1; ld_req_addr = 32'h24; ld_req_funct3 = 3'b010;
    #1;
    tick();
    ld_req_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checkOutput("flush_req_held", mem_req_valid, 32'd1);
    checkOutput("flush_req_addr", mem_req_addr, 32'h24);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1;
    tick();
    mem_resp_valid = 1'b0;
    checkOutput("flush_req_resp_suppressed", ld_resp_valid, 32'd0);

    $display("[TB] stray response in idle");
    mem_resp_valid = 1'b1;
    tick();
    mem_resp_valid = 1'b0;
    checkOutput("stray_resp_ignored", ld_resp_valid, 32'd0);

    $display("[TB] reset during response phase");
    ld_req_valid = 1'b1; ld_req_addr = 32'h3C; ld_req_funct3 = 3'b010; ld_req_rob_id = 6'd33;
    #1;
    tick();
    ld_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rst_mem_req_valid", mem_req_valid, 32'd0);
    checkOutput("rst_mem_req_addr", mem_req_addr, 32'd0);
    checkOutput("rst_ld_resp_data", ld_resp_data, 32'd0);
    checkOutput("rst_ld_resp_rob_id", ld_resp_rob_id, 32'd0);
    mem_resp_valid = 1'b1;
    tick();
    mem_resp_valid = 1'b0;
    checkOutput("rst_late_resp_ignored", ld_resp_valid, 32'd0);

    $display("[TB] randomized transactions");
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 1) == 1) begin
        v = refStore(3'($urandom_range(0, 2)), $urandom, $urandom);
      end else begin
        v          = '{default: '0};
        v.funct3   = ld_f3s[$urandom_range(0, 4)];
        v.addr     = $urandom;
        v.rdata    = $urandom;
        v.exp_addr = v.addr & 32'hFFFF_FFFC;
        v.exp_resp = refLoad(v.funct3, v.addr[1:0], v.rdata);
      end
      v.mem_dly  = $urandom_range(0, 3);
      v.resp_dly = $urandom_range(0, 3);
      applyStimulus(v, 6'($urandom), 7'($urandom));
    end

    $display("[TB] randomized occupancy arbitration");
    for (int k = 0; k < 8; k++) begin
      occ = $urandom_range(0, 15);
      sb_occupancy = 4'(occ);
      st_req_valid = 1'b1;
      ld_req_valid = 1'b1;
      serveOne(ws);
      checkOutput($sformatf("occ%0d_store_wins", occ), ws, (occ >= 6));
      ld_req_valid = 1'b0;
      if (!ws) begin
        serveOne(ws);
        checkOutput("occ_store_follows", ws, 32'd1);
      end
      st_req_valid = 1'b0;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
